pmem_arbiter: RTL and testbench

//  Arbitrates one physical-memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined core.

---
 rtl/pmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_pmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and the D-cache, one line transfer at a time.
// The D-cache wins by default; a streak counter forces an I grant after MAX_DSTREAK back-to-back D grants.
module pmem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy
);

    typedef enum logic [2:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        I_RESP,
        D_RESP
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [LINE_W-1:0] wdata_q,   wdata_d;
    logic              rd_q,      rd_d;
    logic              wr_q,      wr_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic [3:0]        dstreak_q, dstreak_d;

    logic d_req;
    logic i_win;

    assign d_req = d_read | d_write;
    assign i_win = i_read & (~d_req | (dstreak_q == STREAK_MAX));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        dstreak_d = dstreak_q;

        unique case (state_q)
            IDLE: begin
                if (i_win) begin
                    state_d   = I_BUSY;
                    addr_d    = i_addr;
                    wdata_d   = '0;
                    rd_d      = 1'b1;
                    wr_d      = 1'b0;
                    dstreak_d = '0;
                end else if (d_req) begin
                    // A simultaneous read+write request is resolved as a write.
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    rd_d    = ~d_write;
                    wr_d    = d_write;
                    if (!i_read) begin
                        dstreak_d = '0;
                    end else if (dstreak_q != STREAK_MAX) begin
                        dstreak_d = dstreak_q + 4'd1;
                    end
                end
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    state_d   = I_RESP;
                    i_rdata_d = pmem_rdata;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    state_d   = D_RESP;
                    d_rdata_d = pmem_rdata;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                end
            end
            I_RESP:  state_d = IDLE;
            D_RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            dstreak_q <= dstreak_d;
        end
    end

    assign pmem_read  = rd_q;
    assign pmem_write = wr_q;
    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_resp     = (state_q == I_RESP);
    assign d_resp     = (state_q == D_RESP);
    assign arb_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single clients, conflict ordering, starvation limit,
// reset mid-transfer and stray memory responses.
module tb_pmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read, d_read, d_write, pmem_resp;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wdata, pmem_rdata;
    logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
    logic              i_resp, d_resp, pmem_read, pmem_write, arb_busy;
    logic [ADDR_W-1:0] pmem_addr;

    int tests  = 0;
    int failed = 0;
    int both_strobes = 0;
    int proto_err    = 0;

    localparam logic [LINE_W-1:0] L_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] L_WD = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [LINE_W-1:0] L_R1 = {4{32'h1111_2222}};
    localparam logic [LINE_W-1:0] L_R2 = {4{32'h3333_4444}};
    localparam logic [LINE_W-1:0] L_R3 = {8{16'h5A5A}};
    localparam logic [LINE_W-1:0] L_FF = {LINE_W{1'b1}};

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    // Continuous watchdogs, reported through ordinary comparisons at the end.
    always @(negedge clk) begin
        if (pmem_read && pmem_write) both_strobes++;
        if (d_read && d_write) proto_err++;
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
        nclk(2);
        chk("rst_pmem_read",  pmem_read,  0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr",  pmem_addr,  0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_i_resp",     i_resp,     0);
        chk("rst_d_resp",     d_resp,     0);
        chk("rst_i_rdata",    i_rdata,    0);
        chk("rst_d_rdata",    d_rdata,    0);
        chk("rst_busy",       arb_busy,   0);
        rst_n = 1'b1;
        nclk(1);

        // T1: I-cache read alone, memory answers on the 3rd busy cycle
        i_read = 1; i_addr = 16'h1230;
        nclk(1);
        chk("t1_rd",    pmem_read,  1);
        chk("t1_wr",    pmem_write, 0);
        chk("t1_addr",  pmem_addr,  16'h1230);
        chk("t1_busy",  arb_busy,   1);
        nclk(1);
        chk("t1_rd_hold", pmem_read, 1);
        nclk(1);
        pmem_resp = 1; pmem_rdata = L_A5;
        nclk(1);
        pmem_resp = 0; pmem_rdata = '0;
        chk("t1_i_resp",  i_resp,    1);
        chk("t1_i_rdata", i_rdata,   L_A5);
        chk("t1_d_resp",  d_resp,    0);
        chk("t1_rd_drop", pmem_read, 0);
        i_read = 0;
        nclk(1);
        chk("t1_i_resp_1cyc", i_resp,   0);
        chk("t1_idle",        arb_busy, 0);
        chk("t1_rdata_hold",  i_rdata,  L_A5);

        // T2: D-cache write
        d_write = 1; d_addr = 16'h4000; d_wdata = L_WD;
        nclk(1);
        chk("t2_wr",    pmem_write, 1);
        chk("t2_rd",    pmem_read,  0);
        chk("t2_addr",  pmem_addr,  16'h4000);
        chk("t2_wdata", pmem_wdata, L_WD);
        pmem_resp = 1;
        nclk(1);
        pmem_resp = 0;
        chk("t2_d_resp", d_resp,     1);
        chk("t2_i_resp", i_resp,     0);
        chk("t2_wr_drop", pmem_write, 0);
        d_write = 0;
        nclk(1);
        chk("t2_d_resp_1cyc", d_resp, 0);

        // T3: I and D rise together with no streak; D first, then I after one IDLE cycle
        i_read = 1; i_addr = 16'h6000; d_read = 1; d_addr = 16'h5000;
        nclk(1);
        chk("t3_first_addr", pmem_addr, 16'h5000);
        chk("t3_first_rd",   pmem_read, 1);
        pmem_resp = 1; pmem_rdata = L_R1;
        nclk(1);
        pmem_resp = 0;
        chk("t3_d_resp",  d_resp,  1);
        chk("t3_d_rdata", d_rdata, L_R1);
        chk("t3_i_wait",  i_resp,  0);
        d_read = 0;
        nclk(1);
        chk("t3_gap", arb_busy, 0);
        nclk(1);
        chk("t3_second_addr", pmem_addr, 16'h6000);
        chk("t3_second_rd",   pmem_read, 1);
        pmem_resp = 1; pmem_rdata = L_R2;
        nclk(1);
        pmem_resp = 0;
        chk("t3_i_resp",     i_resp,  1);
        chk("t3_i_rdata",    i_rdata, L_R2);
        chk("t3_d_rdata_kept", d_rdata, L_R1);
        chk("t3_d_resp0",    d_resp,  0);
        i_read = 0;
        nclk(1);

        // T4: both held; pattern D,D,D,D,I repeats, proving the streak clears after the I grant
        i_read = 1; i_addr = 16'h7000; d_read = 1;
        for (int k = 0; k < 10; k++) begin
            d_addr = 16'h8000 + 16'(k << 4);
            nclk(1);
            if (k % 5 == 4) chk($sformatf("t4_grant%0d_I", k), pmem_addr, 16'h7000);
            else            chk($sformatf("t4_grant%0d_D", k), pmem_addr, 16'h8000 + 16'(k << 4));
            pmem_resp = 1; pmem_rdata = 128'(k + 1);
            nclk(1);
            pmem_resp = 0;
            if (k % 5 == 4) chk($sformatf("t4_resp%0d_I", k), {i_resp, d_resp}, 2'b10);
            else            chk($sformatf("t4_resp%0d_D", k), {i_resp, d_resp}, 2'b01);
            if (k == 9) begin
                i_read = 0; d_read = 0;
            end
            nclk(1);
        end
        chk("t4_i_rdata", i_rdata, 128'd10);
        chk("t4_d_rdata", d_rdata, 128'd9);

        // T5: reset while D_BUSY abandons the transfer
        d_read = 1; d_addr = 16'h9000;
        nclk(1);
        chk("t5_busy_rd", pmem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_rd",   pmem_read, 0);
        chk("t5_async_busy", arb_busy,  0);
        d_read = 0;
        nclk(1);
        chk("t5_no_resp", d_resp, 0);
        rst_n = 1'b1;
        nclk(1);
        chk("t5_no_resp_after", d_resp, 0);
        d_write = 1; d_addr = 16'hA000; d_wdata = ~L_WD;
        nclk(1);
        chk("t5_fresh_wr",    pmem_write, 1);
        chk("t5_fresh_addr",  pmem_addr,  16'hA000);
        chk("t5_fresh_wdata", pmem_wdata, ~L_WD);
        pmem_resp = 1; pmem_rdata = L_R3;
        nclk(1);
        pmem_resp = 0;
        chk("t5_fresh_resp", d_resp, 1);
        d_write = 0;
        nclk(1);

        // T6: stray memory response while IDLE
        pmem_resp = 1; pmem_rdata = L_FF;
        nclk(1);
        pmem_resp = 0; pmem_rdata = '0;
        chk("t6_i_resp", i_resp,   0);
        chk("t6_d_resp", d_resp,   0);
        chk("t6_idle",   arb_busy, 0);
        chk("t6_i_rdata", i_rdata, 0);
        chk("t6_d_rdata", d_rdata, L_R3);
        nclk(1);
        chk("t6_still_idle", arb_busy, 0);

        chk("never_both_strobes", both_strobes, 0);
        chk("no_rd_wr_overlap",   proto_err,    0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
